// File: rtl/pipe_ctrl_n.sv
// pipe_ctrl_n: valid/ready handshake controller for an NSTAGE-deep in-order
// pipeline, with the inter-stage bus registers, a flush that kills a prefix
// of the pipe, and three saturating performance counters.
//
// Ports:
//   clk          clock, rising edge
//   resetn       synchronous reset, active-low
//   fetch_en     request that stage 0 hold a valid entry
//   stage_over   per-stage "work finished this cycle" (ignored when invalid)
//   stage_bus    slice i is the output bus of stage i (last slice unused)
//   flush        cancel request
//   flush_stage  oldest stage killed by a flush (clamped to NSTAGE-1)
//   clear_cnt    synchronous clear of all counters
//   valid        per-stage valid register
//   allow_in     per-stage "may accept a new entry" flag (combinational)
//   bus_r        slice i is the register feeding stage i+1
//   retire_cnt   entries leaving the last stage
//   bubble_cnt   cycles with the last stage empty
//   flush_cnt    cycles with flush asserted
module pipe_ctrl_n #(
  parameter int NSTAGE = 5,
  parameter int BUS_W  = 160,
  parameter int CNT_W  = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          fetch_en,
  input  logic [NSTAGE-1:0]             stage_over,
  input  logic [NSTAGE*BUS_W-1:0]       stage_bus,
  input  logic                          flush,
  input  logic [3:0]                    flush_stage,
  input  logic                          clear_cnt,
  output logic [NSTAGE-1:0]             valid,
  output logic [NSTAGE-1:0]             allow_in,
  output logic [(NSTAGE-1)*BUS_W-1:0]   bus_r,
  output logic [CNT_W-1:0]              retire_cnt,
  output logic [CNT_W-1:0]              bubble_cnt,
  output logic [CNT_W-1:0]              flush_cnt
);

  localparam int LAST = NSTAGE - 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             en);
    if (en && (cnt != {CNT_W{1'b1}})) return cnt + CNT_W'(1);
    return cnt;
  endfunction

  logic [NSTAGE-1:0] ov;
  logic [NSTAGE-1:0] allow_c;
  logic [NSTAGE-1:0] kill;
  logic [LAST-1:0]   ld;
  logic              down;
  logic              unused_last_bus;

  // The last stage has no consumer on this bus; its slice is never registered.
  assign unused_last_bus = ^stage_bus[NSTAGE*BUS_W-1 -: BUS_W];

  assign ov       = valid & stage_over;
  assign allow_in = allow_c;

  // Ready ripples from the oldest stage back to the entry stage. A running
  // scalar carries the downstream ready so the vector is only written here.
  always_comb begin
    allow_c       = '0;
    down          = ~valid[LAST] | ov[LAST];
    allow_c[LAST] = down;
    for (int i = LAST - 1; i >= 1; i--) begin
      down       = ~valid[i] | (ov[i] & down);
      allow_c[i] = down;
    end
    allow_c[0] = ~valid[0] | (ov[0] & down) | flush;
  end

  // Stages 1..flush_stage are killed; stage index never exceeds LAST, so the
  // clamp of flush_stage to LAST is implicit in the comparison.
  always_comb begin
    kill = '0;
    for (int i = 1; i < NSTAGE; i++) begin
      kill[i] = flush && (int'(flush_stage) >= i);
    end
  end

  always_comb begin
    ld = '0;
    for (int i = 1; i < NSTAGE; i++) begin
      ld[i-1] = ov[i-1] & allow_c[i];
    end
  end

  // ---- stage boundary: valid registers ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid <= '0;
    end else begin
      valid[0] <= fetch_en;
      for (int i = 1; i < NSTAGE; i++) begin
        if (kill[i]) begin
          valid[i] <= 1'b0;
        end else if (allow_c[i]) begin
          valid[i] <= ov[i-1];
        end
      end
    end
  end

  // ---- stage boundary: inter-stage bus registers ----
  // The bus captures on a transfer even when the receiving stage is being
  // flushed; the killed valid bit makes the stale data harmless.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus_r <= '0;
    end else begin
      for (int i = 1; i < NSTAGE; i++) begin
        if (ld[i-1]) begin
          bus_r[(i-1)*BUS_W +: BUS_W] <= stage_bus[(i-1)*BUS_W +: BUS_W];
        end
      end
    end
  end

  // ---- performance counters ----
  always_ff @(posedge clk) begin
    if (!resetn || clear_cnt) begin
      retire_cnt <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      retire_cnt <= sat_inc(retire_cnt, ov[LAST]);
      bubble_cnt <= sat_inc(bubble_cnt, ~valid[LAST]);
      flush_cnt  <= sat_inc(flush_cnt, flush);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Bench for pipe_ctrl_n (NSTAGE=5, BUS_W=16). Two instances share the inputs:
// one with 32-bit counters and one with 4-bit counters for saturation.
module tb_pipe_ctrl_n;

  localparam int N  = 5;
  localparam int BW = 16;

  logic            clk;
  logic            resetn;
  logic            fetch_en;
  logic [N-1:0]    so;
  logic [N*BW-1:0] sbus;
  logic            flush;
  logic [3:0]      fs;
  logic            clear;

  logic [N-1:0]        valid, allow_in, valid4, allow4;
  logic [(N-1)*BW-1:0] bus_r, bus4;
  logic [31:0]         ret, bub, flc;
  logic [3:0]          ret4, bub4, flc4;

  pipe_ctrl_n #(.NSTAGE(N), .BUS_W(BW), .CNT_W(32)) dut (
    .clk(clk), .resetn(resetn), .fetch_en(fetch_en), .stage_over(so),
    .stage_bus(sbus), .flush(flush), .flush_stage(fs), .clear_cnt(clear),
    .valid(valid), .allow_in(allow_in), .bus_r(bus_r),
    .retire_cnt(ret), .bubble_cnt(bub), .flush_cnt(flc));

  pipe_ctrl_n #(.NSTAGE(N), .BUS_W(BW), .CNT_W(4)) dut4 (
    .clk(clk), .resetn(resetn), .fetch_en(fetch_en), .stage_over(so),
    .stage_bus(sbus), .flush(flush), .flush_stage(fs), .clear_cnt(clear),
    .valid(valid4), .allow_in(allow4), .bus_r(bus4),
    .retire_cnt(ret4), .bubble_cnt(bub4), .flush_cnt(flc4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]        v;
    logic [(N-1)*BW-1:0] b;
    logic [31:0]         r, bu, f;
    logic [3:0]          r4, bu4, f4;
  } exp_t;

  exp_t sb_q[$];

  // reference model state
  logic [N-1:0]        m_v;
  logic [(N-1)*BW-1:0] m_b;
  logic [31:0]         m_r, m_bu, m_f;
  logic [3:0]          m_r4, m_bu4, m_f4;
  logic [15:0]         cur_id;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] inc32(input logic [31:0] c, input logic en);
    return (en && c != 32'hFFFF_FFFF) ? c + 32'd1 : c;
  endfunction

  function automatic logic [3:0] inc4(input logic [3:0] c, input logic en);
    return (en && c != 4'hF) ? c + 4'd1 : c;
  endfunction

  // Stage 0 carries the current entry id; stage i>=1 carries what its input
  // register captured. The last slice is ignored by the DUT.
  task automatic drive_bus();
    sbus[0 +: BW] = cur_id;
    for (int i = 1; i < N - 1; i++) sbus[i*BW +: BW] = m_b[(i-1)*BW +: BW];
    sbus[(N-1)*BW +: BW] = 16'hDEAD;
  endtask

  task automatic step();
    logic [N-1:0] ov, al;
    exp_t e;
    int   k;
    logic new_entry;
    #1;
    ov    = m_v & so;
    al[N-1] = ~m_v[N-1] | ov[N-1];
    for (int i = N - 2; i >= 1; i--) al[i] = ~m_v[i] | (ov[i] & al[i+1]);
    al[0] = ~m_v[0] | (ov[0] & al[1]) | flush;
    chk("allow_in", 64'(allow_in), 64'(al));
    chk("allow_in_c4", 64'(allow4), 64'(al));
    e = '0;
    new_entry = 1'b0;
    if (resetn) begin
      k = (int'(fs) > N - 1) ? N - 1 : int'(fs);
      e.v[0] = fetch_en;
      e.b = m_b;
      for (int i = 1; i < N; i++) begin
        if (flush && i <= k) e.v[i] = 1'b0;
        else if (al[i])      e.v[i] = ov[i-1];
        else                 e.v[i] = m_v[i];
        if (ov[i-1] && al[i]) e.b[(i-1)*BW +: BW] = sbus[(i-1)*BW +: BW];
      end
      if (!clear) begin
        e.r   = inc32(m_r, ov[N-1]);
        e.bu  = inc32(m_bu, ~m_v[N-1]);
        e.f   = inc32(m_f, flush);
        e.r4  = inc4(m_r4, ov[N-1]);
        e.bu4 = inc4(m_bu4, ~m_v[N-1]);
        e.f4  = inc4(m_f4, flush);
      end
      new_entry = al[0] & fetch_en;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("valid", 64'(valid), 64'(e.v));
    chk("bus_r", 64'(bus_r), 64'(e.b));
    chk("retire_cnt", 64'(ret), 64'(e.r));
    chk("bubble_cnt", 64'(bub), 64'(e.bu));
    chk("flush_cnt", 64'(flc), 64'(e.f));
    chk("valid_c4", 64'(valid4), 64'(e.v));
    chk("bus_r_c4", 64'(bus4), 64'(e.b));
    chk("retire_cnt_c4", 64'(ret4), 64'(e.r4));
    chk("bubble_cnt_c4", 64'(bub4), 64'(e.bu4));
    chk("flush_cnt_c4", 64'(flc4), 64'(e.f4));
    m_v = e.v;  m_b = e.b;
    m_r = e.r;  m_bu = e.bu;  m_f = e.f;
    m_r4 = e.r4; m_bu4 = e.bu4; m_f4 = e.f4;
    if (new_entry) cur_id = cur_id + 16'd1;
    drive_bus();
  endtask

  task automatic refill();
    fetch_en = 1'b1; so = '1; flush = 1'b0; clear = 1'b0;
    repeat (5) step();
  endtask

  task automatic do_fill();
    logic [N-1:0] pat;
    fetch_en = 1'b1; so = '1; flush = 1'b0; clear = 1'b0;
    pat = '0;
    for (int j = 0; j < N; j++) begin
      step();
      pat = {pat[N-2:0], 1'b1};
      chk("fill_valid", 64'(valid), 64'(pat));
    end
    step();
    chk("fill_retire", 64'(ret), 64'd1);
  endtask

  initial begin
    resetn = 1'b0; fetch_en = 1'b0; so = '0; flush = 1'b0; fs = '0; clear = 1'b0;
    m_v = '0; m_b = '0; m_r = '0; m_bu = '0; m_f = '0;
    m_r4 = '0; m_bu4 = '0; m_f4 = '0;
    cur_id = 16'h0100;
    drive_bus();
    repeat (2) @(posedge clk);
    #1;

    // reset state
    step();
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_allow", 64'(allow_in), 64'h1F);
    chk("rst_retire", 64'(ret), 64'd0);

    resetn = 1'b1;
    do_fill();
    chk("fill_bubble", 64'(bub), 64'd5);

    // last stage stalls for three cycles
    so = 5'b01111;
    repeat (3) begin
      #1;
      chk("stall_allow", 64'(allow_in), 64'd0);
      step();
      chk("stall_valid", 64'(valid), 64'h1F);
    end
    so = '1;
    repeat (3) step();
    chk("stall_retire", 64'(ret), 64'd4);

    // full flush, clamped flush_stage, partial flush, flush_stage 0
    refill();
    flush = 1'b1; fs = 4'd4; step(); flush = 1'b0;
    chk("flush4_valid", 64'(valid), 64'h01);
    chk("flush4_cnt", 64'(flc), 64'd1);
    refill();
    flush = 1'b1; fs = 4'd9; step(); flush = 1'b0;
    chk("flush9_valid", 64'(valid), 64'h01);
    chk("flush9_cnt", 64'(flc), 64'd2);
    refill();
    flush = 1'b1; fs = 4'd2; step(); flush = 1'b0;
    chk("flush2_valid", 64'(valid), 64'b11001);
    refill();
    flush = 1'b1; fs = 4'd0; step(); flush = 1'b0;
    chk("flush0_valid", 64'(valid), 64'h1F);

    // counter saturation and clear priority
    refill();
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_retire", 64'(ret), 64'd0);
    repeat (20) step();
    chk("sat_retire32", 64'(ret), 64'd20);
    chk("sat_retire4", 64'(ret4), 64'd15);
    chk("sat_bubble", 64'(bub), 64'd0);
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_sat_retire4", 64'(ret4), 64'd0);
    chk("clr_sat_retire32", 64'(ret), 64'd0);

    // reset mid-run with a full pipe and a concurrent flush
    flush = 1'b1; fs = 4'd4; resetn = 1'b0; step();
    chk("mid_rst_valid", 64'(valid), 64'd0);
    chk("mid_rst_bus", 64'(bus_r), 64'd0);
    chk("mid_rst_flush", 64'(flc), 64'd0);
    chk("mid_rst_bubble", 64'(bub), 64'd0);
    resetn = 1'b1; flush = 1'b0;
    do_fill();

    // random traffic, including stage_over on empty stages
    for (int c = 0; c < 400; c++) begin
      fetch_en = ($urandom_range(0, 3) != 0);
      so       = N'($urandom);
      flush    = ($urandom_range(0, 9) == 0);
      fs       = 4'($urandom);
      clear    = ($urandom_range(0, 29) == 0);
      resetn   = ($urandom_range(0, 59) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
